// File: rtl/uart_param.sv
// Parameterised UART: shared 16x oversample tick, TX and RX engines.
// Ports: clk, rst_n, cfg_* frame setup, tx_* word in / serial out, rx_* serial in / word out.
module uart_param #(
  parameter int DW    = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [3:0]       cfg_dbits,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             cfg_stop2,
  input  logic [DW-1:0]    tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_out,
  input  logic             rx_in,
  output logic [DW-1:0]    rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  function automatic logic [3:0] clamp_bits(input logic [3:0] d);
    if (d < 4'd5)
      return 4'd5;
    else if (d > 4'(DW))
      return 4'(DW);
    else
      return d;
  endfunction

  function automatic logic [DW-1:0] bit_mask(input logic [3:0] d);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < DW; i++)
      m[i] = (i < int'(d));
    return m;
  endfunction

  logic [3:0] dbits_c;
  assign dbits_c = clamp_bits(cfg_dbits);

  // Tick divider; first cycle after reset loads cfg_div.
  logic [DIV_W-1:0] div_cnt;
  logic             div_run;
  logic             tick;

  assign tick = div_run && (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      div_run <= 1'b0;
    end else if (!div_run || div_cnt == '0) begin
      div_cnt <= cfg_div;
      div_run <= 1'b1;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // ---------------- TX ----------------
  state_t        tx_st, tx_st_n;
  logic [3:0]    tx_tc, tx_tc_n;
  logic [3:0]    tx_idx, tx_idx_n;
  logic [DW-1:0] tx_sh, tx_sh_n;
  logic [3:0]    tx_nb, tx_nb_n;
  logic          tx_pen, tx_pen_n;
  logic          tx_pb, tx_pb_n;
  logic          tx_s2, tx_s2_n;
  logic          tx_end;

  assign tx_end = tick && (tx_tc == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st  <= S_IDLE;
      tx_tc  <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_nb  <= 4'd5;
      tx_pen <= 1'b0;
      tx_pb  <= 1'b0;
      tx_s2  <= 1'b0;
    end else begin
      tx_st  <= tx_st_n;
      tx_tc  <= tx_tc_n;
      tx_idx <= tx_idx_n;
      tx_sh  <= tx_sh_n;
      tx_nb  <= tx_nb_n;
      tx_pen <= tx_pen_n;
      tx_pb  <= tx_pb_n;
      tx_s2  <= tx_s2_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_tc_n  = tx_tc;
    tx_idx_n = tx_idx;
    tx_sh_n  = tx_sh;
    tx_nb_n  = tx_nb;
    tx_pen_n = tx_pen;
    tx_pb_n  = tx_pb;
    tx_s2_n  = tx_s2;
    tx_ready = 1'b0;
    tx_out   = 1'b1;
    if (tx_st != S_IDLE && tick)
      tx_tc_n = tx_tc + 4'd1;
    unique case (tx_st)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          tx_sh_n  = tx_data;
          tx_nb_n  = dbits_c;
          tx_pen_n = cfg_par_en;
          tx_pb_n  = (^(tx_data & bit_mask(dbits_c))) ^ cfg_par_odd;
          tx_s2_n  = cfg_stop2;
          tx_tc_n  = '0;
          tx_idx_n = '0;
          tx_st_n  = S_START;
        end
      end
      S_START: begin
        tx_out = 1'b0;
        if (tx_end) begin
          tx_idx_n = '0;
          tx_st_n  = S_DATA;
        end
      end
      S_DATA: begin
        tx_out = tx_sh[0];
        if (tx_end) begin
          tx_sh_n = tx_sh >> 1;
          if (tx_idx == tx_nb - 4'd1) begin
            tx_idx_n = '0;
            tx_st_n  = tx_pen ? S_PAR : S_STOP;
          end else begin
            tx_idx_n = tx_idx + 4'd1;
          end
        end
      end
      S_PAR: begin
        tx_out = tx_pb;
        if (tx_end) begin
          tx_idx_n = '0;
          tx_st_n  = S_STOP;
        end
      end
      S_STOP: begin
        tx_out = 1'b1;
        if (tx_end) begin
          if (tx_s2 && tx_idx == 4'd0)
            tx_idx_n = 4'd1;
          else
            tx_st_n = S_IDLE;
        end
      end
      default: tx_st_n = S_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  logic [1:0] sync;
  logic       rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync <= 2'b11;
    else
      sync <= {sync[0], rx_in};
  end

  assign rxs = sync[1];

  state_t        rx_st, rx_st_n;
  logic [3:0]    rx_tc, rx_tc_n;
  logic [3:0]    rx_idx, rx_idx_n;
  logic [DW-1:0] rx_sh, rx_sh_n;
  logic [1:0]    rx_v, rx_v_n;
  logic [3:0]    rx_nb, rx_nb_n;
  logic          rx_pen, rx_pen_n;
  logic          rx_podd, rx_podd_n;
  logic          rx_pbit, rx_pbit_n;
  logic          rx_samp, rx_end, maj;
  logic          done, done_perr, done_ferr;

  assign rx_samp = tick && (rx_tc == 4'd9);
  assign rx_end  = tick && (rx_tc == 4'd15);
  // Votes from ticks 7 and 8 plus the live tick-9 sample.
  assign maj = (rx_v[1] & rx_v[0]) | (rx_v[1] & rxs) | (rx_v[0] & rxs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st   <= S_IDLE;
      rx_tc   <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_v    <= 2'b11;
      rx_nb   <= 4'd5;
      rx_pen  <= 1'b0;
      rx_podd <= 1'b0;
      rx_pbit <= 1'b0;
    end else begin
      rx_st   <= rx_st_n;
      rx_tc   <= rx_tc_n;
      rx_idx  <= rx_idx_n;
      rx_sh   <= rx_sh_n;
      rx_v    <= rx_v_n;
      rx_nb   <= rx_nb_n;
      rx_pen  <= rx_pen_n;
      rx_podd <= rx_podd_n;
      rx_pbit <= rx_pbit_n;
    end
  end

  always_comb begin
    rx_st_n   = rx_st;
    rx_tc_n   = rx_tc;
    rx_idx_n  = rx_idx;
    rx_sh_n   = rx_sh;
    rx_v_n    = rx_v;
    rx_nb_n   = rx_nb;
    rx_pen_n  = rx_pen;
    rx_podd_n = rx_podd;
    rx_pbit_n = rx_pbit;
    done      = 1'b0;
    done_perr = 1'b0;
    done_ferr = 1'b0;
    if (rx_st != S_IDLE && tick) begin
      rx_tc_n = rx_tc + 4'd1;
      if (rx_tc == 4'd7)
        rx_v_n[1] = rxs;
      if (rx_tc == 4'd8)
        rx_v_n[0] = rxs;
    end
    unique case (rx_st)
      S_IDLE: begin
        if (!rxs) begin
          rx_st_n   = S_START;
          rx_tc_n   = '0;
          rx_idx_n  = '0;
          rx_sh_n   = '0;
          rx_nb_n   = dbits_c;
          rx_pen_n  = cfg_par_en;
          rx_podd_n = cfg_par_odd;
        end
      end
      S_START: begin
        if (rx_samp && maj)
          rx_st_n = S_IDLE;
        else if (rx_end)
          rx_st_n = S_DATA;
      end
      S_DATA: begin
        if (rx_samp) begin
          for (int i = 0; i < DW; i++)
            if (rx_idx == 4'(i))
              rx_sh_n[i] = maj;
        end
        if (rx_end) begin
          if (rx_idx == rx_nb - 4'd1)
            rx_st_n = rx_pen ? S_PAR : S_STOP;
          else
            rx_idx_n = rx_idx + 4'd1;
        end
      end
      S_PAR: begin
        if (rx_samp)
          rx_pbit_n = maj;
        if (rx_end)
          rx_st_n = S_STOP;
      end
      S_STOP: begin
        // Leave at the stop centre so the next start edge is not missed.
        if (rx_samp) begin
          done      = 1'b1;
          done_perr = rx_pen && ((^rx_sh ^ rx_podd) != rx_pbit);
          done_ferr = !maj;
          rx_st_n   = S_IDLE;
        end
      end
      default: rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_sh;
          rx_parity_err <= done_perr;
          rx_frame_err  <= done_ferr;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Scoreboard bench for uart_param: TX line monitor and RX handshake monitor.
// Directed frames with hand-computed expectations; cfg_div=3 gives 64 clk per bit.
module tb_uart_param;

  localparam int DW = 8;
  localparam int BT = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   cfg_div;
  logic [3:0]    cfg_dbits;
  logic          cfg_par_en, cfg_par_odd, cfg_stop2;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready, tx_out;
  logic          rx_in, rx_drv, loop;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ready;
  logic          rx_parity_err, rx_frame_err, rx_overrun;

  assign rx_in = loop ? tx_out : rx_drv;

  always #5 clk = ~clk;

  uart_param #(.DW(DW), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div),
    .cfg_dbits(cfg_dbits), .cfg_par_en(cfg_par_en),
    .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out),
    .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  typedef struct {
    logic [7:0] d;
    int         nb;
    logic       pen;
    logic       pb;
    int         ns;
  } tx_exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } rx_exp_t;

  tx_exp_t txq[$];
  rx_exp_t rxq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic pe,
                         input logic po, input logic s2);
    cfg_dbits   = nb;
    cfg_par_en  = pe;
    cfg_par_odd = po;
    cfg_stop2   = s2;
  endtask

  task automatic tx_send(input logic [7:0] d);
    int n;
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 5000) begin
      cyc(1);
      n++;
    end
    if (n >= 5000)
      chk("tx_accept_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input bit g);
    for (int c = 0; c < BT; c++) begin
      rx_drv = (g && c >= 36 && c < 40) ? ~b : b;
      cyc(1);
    end
  endtask

  task automatic inject(input logic [7:0] d, input int nb, input bit pen,
                        input logic pb, input logic sb, input int ns,
                        input int gl);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++)
      drive_bit(d[i], i == gl);
    if (pen)
      drive_bit(pb, 1'b0);
    drive_bit(sb, 1'b0);
    for (int s = 1; s < ns; s++)
      drive_bit(1'b1, 1'b0);
    rx_drv = 1'b1;
  endtask

  task automatic push_tx(input logic [7:0] d, input int nb, input logic pen,
                         input logic pb, input int ns);
    tx_exp_t e;
    e.d = d; e.nb = nb; e.pen = pen; e.pb = pb; e.ns = ns;
    txq.push_back(e);
  endtask

  task automatic push_rx(input logic [7:0] d, input logic pe,
                         input logic fe, input logic ov);
    rx_exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.ov = ov;
    rxq.push_back(e);
  endtask

  // TX monitor: samples each bit of the line at its centre.
  initial begin : tx_mon
    tx_exp_t e;
    int n;
    forever begin
      if (txq.size() == 0) begin
        @(negedge clk);
      end else begin
        e = txq.pop_front();
        n = 0;
        while (tx_out !== 1'b0 && n < 20000) begin
          @(negedge clk);
          n++;
        end
        if (n >= 20000)
          chk("tx_start_timeout", 32'(tx_out), 32'd0);
        repeat (BT / 2) @(negedge clk);
        chk("tx_start", 32'(tx_out), 32'd0);
        for (int i = 0; i < e.nb; i++) begin
          repeat (BT) @(negedge clk);
          chk($sformatf("tx_bit%0d_%02h", i, e.d), 32'(tx_out), 32'(e.d[i]));
        end
        if (e.pen) begin
          repeat (BT) @(negedge clk);
          chk("tx_parity", 32'(tx_out), 32'(e.pb));
        end
        for (int s = 0; s < e.ns; s++) begin
          repeat (BT) @(negedge clk);
          chk("tx_stop", 32'(tx_out), 32'd1);
        end
        n = 0;
        while (!tx_ready && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("tx_ready_timing", 32'(n >= 26 && n <= 36), 32'd1);
      end
    end
  end

  // RX monitor: compares every accepted word against the scoreboard.
  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) begin
        if (rxq.size() == 0) begin
          chk("rx_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          e = rxq.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e.d));
          chk("rx_parity_err", 32'(rx_parity_err), 32'(e.pe));
          chk("rx_frame_err", 32'(rx_frame_err), 32'(e.fe));
          chk("rx_overrun", 32'(rx_overrun), 32'(e.ov));
        end
      end
    end
  end

  initial begin : main
    int n;
    rst_n    = 1'b0;
    cfg_div  = 16'd3;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    tx_data  = '0;
    tx_valid = 1'b0;
    rx_drv   = 1'b1;
    loop     = 1'b0;
    rx_ready = 1'b1;
    cyc(3);
    chk("rst_tx_out", 32'(tx_out), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_flags", 32'({rx_parity_err, rx_frame_err, rx_overrun}), 32'd0);
    rst_n = 1'b1;
    cyc(5);

    // 8N1 0xA5
    push_tx(8'hA5, 8, 1'b0, 1'b0, 1);
    tx_send(8'hA5);
    cyc(11 * BT);

    // loopback 7E2 0x35, parity bit 0
    set_cfg(4'd7, 1'b1, 1'b0, 1'b1);
    loop = 1'b1;
    push_tx(8'h35, 7, 1'b1, 1'b0, 2);
    push_rx(8'h35, 1'b0, 1'b0, 1'b0);
    tx_send(8'h35);
    cyc(12 * BT);

    // dbits clamp: 2 -> 5, 15 -> 8
    set_cfg(4'd2, 1'b0, 1'b0, 1'b0);
    push_tx(8'hF3, 5, 1'b0, 1'b0, 1);
    push_rx(8'h13, 1'b0, 1'b0, 1'b0);
    tx_send(8'hF3);
    cyc(9 * BT);
    set_cfg(4'd15, 1'b0, 1'b0, 1'b0);
    push_tx(8'hC6, 8, 1'b0, 1'b0, 1);
    push_rx(8'hC6, 1'b0, 1'b0, 1'b0);
    tx_send(8'hC6);
    cyc(12 * BT);
    loop = 1'b0;

    // 8O1 injection: wrong parity, good frame, bad stop
    set_cfg(4'd8, 1'b1, 1'b1, 1'b0);
    push_rx(8'h0F, 1'b1, 1'b0, 1'b0);
    inject(8'h0F, 8, 1'b1, 1'b0, 1'b1, 1, -1);
    push_rx(8'h0F, 1'b0, 1'b0, 1'b0);
    inject(8'h0F, 8, 1'b1, 1'b1, 1'b1, 1, -1);
    push_rx(8'h0F, 1'b0, 1'b1, 1'b0);
    inject(8'h0F, 8, 1'b1, 1'b1, 1'b0, 1, -1);
    cyc(3 * BT);

    // glitches, 8N1
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    rx_drv = 1'b0;
    cyc(8);
    rx_drv = 1'b1;
    cyc(12 * BT);
    chk("glitch_no_valid", 32'(rx_valid), 32'd0);
    push_rx(8'h5C, 1'b0, 1'b0, 1'b0);
    inject(8'h5C, 8, 1'b0, 1'b0, 1'b1, 1, 2);
    cyc(2 * BT);

    // overrun
    rx_ready = 1'b0;
    push_rx(8'h11, 1'b0, 1'b0, 1'b1);
    inject(8'h11, 8, 1'b0, 1'b0, 1'b1, 1, -1);
    inject(8'h22, 8, 1'b0, 1'b0, 1'b1, 1, -1);
    cyc(BT);
    chk("ovr_valid_held", 32'(rx_valid), 32'd1);
    chk("ovr_data_held", 32'(rx_data), 32'h11);
    chk("ovr_flag", 32'(rx_overrun), 32'd1);
    rx_ready = 1'b1;
    cyc(3);
    chk("ovr_cleared", 32'(rx_overrun), 32'd0);
    chk("ovr_valid_cleared", 32'(rx_valid), 32'd0);

    // back-to-back loopback TX/RX
    loop = 1'b1;
    push_tx(8'h3C, 8, 1'b0, 1'b0, 1);
    push_rx(8'h3C, 1'b0, 1'b0, 1'b0);
    push_tx(8'hC3, 8, 1'b0, 1'b0, 1);
    push_rx(8'hC3, 1'b0, 1'b0, 1'b0);
    tx_send(8'h3C);
    tx_send(8'hC3);
    cyc(13 * BT);

    // reset during a TX data bit
    tx_send(8'h00);
    cyc(3 * BT);
    chk("pre_rst_line_low", 32'(tx_out), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_out", 32'(tx_out), 32'd1);
    chk("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
    cyc(4);
    rst_n = 1'b1;
    cyc(2 * BT);
    chk("rst_mid_no_rx", 32'(rx_valid), 32'd0);
    push_tx(8'h5A, 8, 1'b0, 1'b0, 1);
    push_rx(8'h5A, 1'b0, 1'b0, 1'b0);
    tx_send(8'h5A);
    cyc(12 * BT);

    n = 0;
    while ((txq.size() != 0 || rxq.size() != 0) && n < 5000) begin
      cyc(1);
      n++;
    end
    chk("txq_drained", 32'(txq.size()), 32'd0);
    chk("rxq_drained", 32'(rxq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 SHALL have parameter DW, default 8, meaning maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16, meaning baud-divisor width.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_div  input  DIV_W  oversample-tick period minus 1 (tick = 16x baud).
REQ-006 SHALL have port cfg_dbits  input  4  data bits per frame, 5..DW.
REQ-007 SHALL have port cfg_par_en  input  1  parity bit present.
REQ-008 SHALL have port cfg_par_odd  input  1  1 = odd parity, 0 = even parity.
REQ-009 SHALL have port cfg_stop2  input  1  1 = two stop bits, 0 = one.
REQ-010 SHALL have port tx_data  input  DW  transmit word, LSB sent first.
REQ-011 SHALL have port tx_valid  input  1  transmit request.
REQ-012 SHALL have port tx_ready  output  1  transmitter can accept a word.
REQ-013 SHALL have port tx_out  output  1  serial line out, idle high.
REQ-014 SHALL have port rx_in  input  1  serial line in, asynchronous.
REQ-015 SHALL have port rx_data  output  DW  received word, zero-extended above cfg_dbits.
REQ-016 SHALL have port rx_valid  output  1  rx_data and flags valid.
REQ-017 SHALL have port rx_ready  input  1  consumer accepts received word.
REQ-018 SHALL have port rx_parity_err, rx_frame_err  output  1 each  errors for the word on rx_data.
REQ-019 SHALL have port rx_overrun  output  1  sticky, a word was lost.

Function
REQ-020 SHALL generate tick: down-counter reloads cfg_div, one-cycle tick when it reaches 0; cfg_div=0 gives tick every cycle; shared by TX and RX.
REQ-021 SHALL clamp cfg_dbits below 5 to 5 and above DW to DW.
REQ-022 SHALL sample cfg_* in TX at accept, in RX at start-edge detection; mid-frame config changes do not affect the frame in flight.
REQ-023 TX SHALL use states IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE.
REQ-024 TX SHALL accept on tx_valid&tx_ready, then drive tx_out low next cycle; each bit lasts exactly 16 ticks.
REQ-025 TX SHALL send cfg_dbits data bits LSB first, then parity if enabled, then 16 (one stop) or 32 (two stop) ticks of high, then return to IDLE.
REQ-026 Parity SHALL be XOR of the transmitted data bits only, inverted when cfg_par_odd=1.
REQ-027 TX SHALL accept back-to-back words: tx_ready rises on the cycle after the final stop tick.
REQ-028 RX SHALL double-flop rx_in before use; idle line assumed high.
REQ-029 RX SHALL use states IDLE, START, DATA, PARITY, STOP; synchronized low in IDLE enters START with tick count 0.
REQ-030 RX SHALL take samples at ticks 7, 8, 9 of every bit and use the 2-of-3 majority.
REQ-031 RX SHALL return to IDLE without output if start majority is 1 (false start).
REQ-032 RX SHALL check parity when enabled and set parity error on mismatch; stop majority 0 sets frame error (only the first stop bit is checked).
REQ-033 RX SHALL return to IDLE after stop tick 9 so the next start edge is caught without a half-bit gap.
REQ-034 RX SHALL on completion load rx_data, rx_parity_err and rx_frame_err and set rx_valid if rx_valid=0 or rx_ready=1 that cycle.
REQ-035 rx_valid SHALL hold, with data and flags stable, until rx_valid&rx_ready; it clears next cycle unless a new word loads the same cycle.
REQ-036 If a word completes while rx_valid=1 and rx_ready=0, it SHALL be dropped, rx_overrun set, and held data unchanged.
REQ-037 rx_overrun SHALL clear on the next rx_valid&rx_ready handshake.
REQ-038 TX and RX SHALL operate fully independently, including simultaneously.

Reset
REQ-039 rst_n low SHALL asynchronously force all states to IDLE and the tick counter to cfg_div reload on release.
REQ-040 Reset values: tx_out=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags=0, synchronizer flops=1.
REQ-041 Reset mid-frame SHALL abort the frame with no partial rx_valid, and tx_out=1 immediately.

Verification
REQ-042 Test: cfg_div=3, 8N1, send 0xA5 -> tx_out low 64 clk, bits 1,0,1,0,0,1,0,1 at 64 clk each, high 64 clk, tx_ready=1.
REQ-043 Test: loopback tx_out->rx_in, 7E2, word 0x35 -> rx_valid, rx_data=0x35, parity bit 0, stop high 32 ticks, no errors.
REQ-044 Test: RX odd parity, inject wrong parity on 0x0F -> rx_parity_err=1, rx_data=0x0F; inject 0 stop -> rx_frame_err=1.
REQ-045 Test: 2-tick low glitch on idle rx_in -> no rx_valid; 1-tick glitch at bit centre -> majority rejects it, data correct.
REQ-046 Test: rx_ready=0, receive 0x11 then 0x22 -> rx_data=0x11, rx_overrun=1; handshake clears both.
REQ-047 Test: assert rst_n low mid-TX data bit -> tx_out=1 same cycle; after release a new 0x5A frame transmits correctly.
